// File: rtl/mem_access_aligner.sv
// Sequential load/store aligner between the MEM stage and the data-memory bus.
// Splits bus-word-crossing accesses into two beats and right-justifies and extends load data.
module mem_access_aligner #(
  parameter int unsigned BUS_BYTES      = 4,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned MISALIGN_SPLIT = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [1:0]             req_size,
  input  logic                   req_signed,
  input  logic [ADDR_W-1:0]      req_addr,
  input  logic [8*BUS_BYTES-1:0] req_wdata,
  output logic                   resp_valid,
  output logic                   resp_err,
  output logic [8*BUS_BYTES-1:0] resp_rdata,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [BUS_BYTES-1:0]   mem_be,
  output logic [8*BUS_BYTES-1:0] mem_wdata,
  input  logic                   mem_ack,
  input  logic [8*BUS_BYTES-1:0] mem_rdata
);
  localparam int unsigned W  = 8 * BUS_BYTES;
  localparam int unsigned OB = $clog2(BUS_BYTES);

  typedef enum logic [2:0] {StIdle, StBeat0, StBeat1, StResp, StErr} state_e;

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              signed_q, signed_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [W-1:0]      wdata_q, wdata_d;
  logic              cross_q, cross_d;
  logic [W-1:0]      gather_q, gather_d;

  logic [OB-1:0]          off, off_in;
  int unsigned            nb, nb_in;
  logic                   mis_in;
  logic [BUS_BYTES-1:0]   nb_mask;
  logic [W-1:0]           lane_mask;
  logic [ADDR_W-1:0]      base_addr;
  logic [2*BUS_BYTES-1:0] be_wide;
  logic [2*W-1:0]         wdata_wide;
  logic                   sign_ext;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      we_q     <= 1'b0;
      size_q   <= '0;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cross_q  <= 1'b0;
      gather_q <= '0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cross_q  <= cross_d;
      gather_q <= gather_d;
    end
  end

  // Lane geometry of the latched request; the upper halves of the wide vectors form beat 1.
  always_comb begin
    off = addr_q[OB-1:0];
    nb  = 32'd1 << size_q;
    for (int i = 0; i < BUS_BYTES; i++) begin
      nb_mask[i]          = (i < nb);
      lane_mask[8*i +: 8] = {8{nb_mask[i]}};
    end
    base_addr  = {addr_q[ADDR_W-1:OB], {OB{1'b0}}};
    be_wide    = {{BUS_BYTES{1'b0}}, nb_mask} << off;
    wdata_wide = {{W{1'b0}}, wdata_q} << (8 * off);
  end

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    size_d   = size_q;
    signed_d = signed_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cross_d  = cross_q;
    gather_d = gather_q;
    off_in   = req_addr[OB-1:0];
    nb_in    = 32'd1 << req_size;
    mis_in   = (32'(off_in) & (nb_in - 32'd1)) != 32'd0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          we_d     = req_we;
          size_d   = req_size;
          signed_d = req_signed;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          cross_d  = (32'(off_in) + nb_in) > BUS_BYTES;
          gather_d = '0;
          if ((32'(req_size) > OB) || (mis_in && (MISALIGN_SPLIT == 0))) state_d = StErr;
          else                                                           state_d = StBeat0;
        end
      end
      StBeat0: begin
        if (mem_ack) begin
          gather_d = mem_rdata >> (8 * off);
          state_d  = cross_q ? StBeat1 : StResp;
        end
      end
      StBeat1: begin
        if (mem_ack) begin
          gather_d = gather_q | (mem_rdata << (8 * (BUS_BYTES - 32'(off))));
          state_d  = StResp;
        end
      end
      StResp:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = '0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_be     = '0;
    mem_wdata  = '0;
    sign_ext   = 1'b0;
    unique case (state_q)
      StIdle: req_ready = 1'b1;
      StBeat0: begin
        mem_req   = 1'b1;
        mem_we    = we_q;
        mem_addr  = base_addr;
        mem_be    = be_wide[BUS_BYTES-1:0];
        mem_wdata = wdata_wide[W-1:0];
      end
      StBeat1: begin
        mem_req   = 1'b1;
        mem_we    = we_q;
        mem_addr  = base_addr + ADDR_W'(BUS_BYTES);
        mem_be    = be_wide[2*BUS_BYTES-1:BUS_BYTES];
        mem_wdata = wdata_wide[2*W-1:W];
      end
      StResp: begin
        resp_valid = 1'b1;
        if (!we_q) begin
          // Full-width accesses have an all-ones lane mask, so extension is a no-op there.
          sign_ext   = signed_q && gather_q[8*nb-1];
          resp_rdata = (gather_q & lane_mask) | (sign_ext ? ~lane_mask : '0);
        end
      end
      StErr: begin
        resp_valid = 1'b1;
        resp_err   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
